// File: rtl/uart_receiver.sv
// 8N1 UART receiver with 16x oversampling, MSB-first data order, mid-bit sampling.
// Reports characters through a charReceived/readAck level handshake with framing and overrun flags.
module uart_receiver #(
  parameter int CLKS_PER_TICK = 326
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       DataIn,
  input  logic       readAck,
  output logic [7:0] DataOut,
  output logic       charReceived,
  output logic       framingError,
  output logic       overrun,
  output logic       busy,
  output logic [1:0] state_dbg
);

  // Handshake: charReceived is a level that rises when a character is loaded into
  // DataOut and falls the cycle after readAck is sampled high; a new character
  // arriving in the same cycle as readAck wins and keeps charReceived high.

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam int TW = (CLKS_PER_TICK > 2) ? $clog2(CLKS_PER_TICK) : 1;

  state_t        state;
  logic [TW-1:0] tick_cnt;
  logic [3:0]    btick;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          sync1;
  logic          sync2;
  logic          prev;
  logic          tick;
  logic          sample;

  assign tick      = (tick_cnt == TW'(CLKS_PER_TICK - 1));
  assign sample    = tick && (btick == 4'd7);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state        <= IDLE;
      tick_cnt     <= '0;
      btick        <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      sync1        <= 1'b1;
      sync2        <= 1'b1;
      prev         <= 1'b1;
      DataOut      <= '0;
      charReceived <= 1'b0;
      framingError <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sync1        <= DataIn;
      sync2        <= sync1;
      prev         <= sync2;
      framingError <= 1'b0;
      if (readAck) charReceived <= 1'b0;

      if (state == IDLE)  tick_cnt <= '0;
      else if (tick)      tick_cnt <= '0;
      else                tick_cnt <= tick_cnt + 1'b1;

      // Bit-tick index wraps every 16 ticks, so each mid-bit sample lands 16 ticks after the last.
      if (state != IDLE && tick) btick <= btick + 1'b1;

      case (state)
        IDLE: begin
          btick   <= '0;
          bit_cnt <= '0;
          if (prev && !sync2) state <= START;
        end
        START: begin
          if (sample) state <= sync2 ? IDLE : DATA;
        end
        DATA: begin
          if (sample) begin
            shreg   <= {shreg[6:0], sync2};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= STOP;
          end
        end
        STOP: begin
          if (sample) begin
            state <= IDLE;
            if (sync2) begin
              DataOut      <= shreg;
              charReceived <= 1'b1;
              if (charReceived && !readAck) overrun <= 1'b1;
            end else begin
              framingError <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver at CLKS_PER_TICK=4 (64 clocks per bit): vector table,
// hand-written corner sequences and a randomized frame stream against a frame-level model.
module tb_uart_receiver;

  localparam int BIT_CLKS = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic       DataIn;
  logic       readAck;
  logic [7:0] DataOut;
  logic       charReceived;
  logic       framingError;
  logic       overrun;
  logic       busy;
  logic [1:0] state_dbg;

  int checks = 0;
  int errors = 0;
  int fe_cycles = 0;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       ack;
    logic [7:0] exp_dout;
    logic       exp_cr;
    logic       exp_ov;
    int         exp_fe;
  } vec_t;

  vec_t tbl[7];

  logic [7:0] m_dout;
  logic       m_cr;
  logic       m_ov;

  uart_receiver #(.CLKS_PER_TICK(4)) dut (
    .CLOCK_50    (clk),
    .reset       (reset),
    .DataIn      (DataIn),
    .readAck     (readAck),
    .DataOut     (DataOut),
    .charReceived(charReceived),
    .framingError(framingError),
    .overrun     (overrun),
    .busy        (busy),
    .state_dbg   (state_dbg)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (framingError === 1'b1) fe_cycles++;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    DataIn = b;
    repeat (BIT_CLKS) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    DataIn = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    @(posedge clk);
    #1;
    drive_bit(1'b0);
    for (int i = 7; i >= 0; i--) drive_bit(d[i]);
    drive_bit(stop);
    DataIn = 1'b1;
  endtask

  task automatic do_ack();
    readAck = 1'b1;
    @(posedge clk);
    #1;
    readAck = 1'b0;
    check("ack_clears_cr", charReceived, 1'b0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int fe0;
    fe0 = fe_cycles;
    send_frame(v.data, v.stop);
    if (!v.stop) idle(16);
    check({tag, "_dout"}, DataOut, v.exp_dout);
    check({tag, "_cr"}, charReceived, v.exp_cr);
    check({tag, "_ov"}, overrun, v.exp_ov);
    check({tag, "_fe"}, fe_cycles - fe0, v.exp_fe);
    if (v.ack) do_ack();
  endtask

  initial begin
    int fe0;
    tbl[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 0};
    tbl[1] = '{8'h3C, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1};
    tbl[2] = '{8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 0};
    tbl[3] = '{8'hFE, 1'b1, 1'b1, 8'hFE, 1'b1, 1'b1, 0};
    tbl[4] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 0};
    tbl[5] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 0};
    tbl[6] = '{8'h5A, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 0};

    reset = 1'b1;
    DataIn = 1'b1;
    readAck = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_dout", DataOut, 8'h00);
    check("rst_cr", charReceived, 1'b0);
    check("rst_fe", framingError, 1'b0);
    check("rst_ov", overrun, 1'b0);
    check("rst_busy", busy, 1'b0);
    idle(10);

    // Short low glitch on an idle line
    fe0 = fe_cycles;
    DataIn = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("glitch_busy_high", busy, 1'b1);
    idle(300);
    check("glitch_busy", busy, 1'b0);
    check("glitch_cr", charReceived, 1'b0);
    check("glitch_ov", overrun, 1'b0);
    check("glitch_fe", fe_cycles - fe0, 0);

    for (int i = 0; i < 4; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Reset in the middle of D4 of 0x55
    fe0 = fe_cycles;
    @(posedge clk);
    #1;
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    DataIn = 1'b1;
    repeat (BIT_CLKS / 2) @(posedge clk);
    #1;
    check("midrst_busy_before", busy, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    DataIn = 1'b1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_dout", DataOut, 8'h00);
    check("midrst_cr", charReceived, 1'b0);
    check("midrst_ov", overrun, 1'b0);

    // Line activity while reset is held
    reset = 1'b1;
    for (int i = 0; i < 200; i++) begin
      DataIn = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    idle(10);
    check("rsthold_dout", DataOut, 8'h00);
    check("rsthold_cr", charReceived, 1'b0);
    check("rsthold_busy", busy, 1'b0);

    send_frame(8'h81, 1'b1);
    check("clean81_dout", DataOut, 8'h81);
    check("clean81_cr", charReceived, 1'b1);
    check("clean81_ov", overrun, 1'b0);
    check("clean81_fe", fe_cycles - fe0, 0);

    // readAck lands in the same cycle as the stop-bit sample
    fork
      send_frame(8'h42, 1'b1);
      begin
        repeat (611) @(posedge clk);
        #1;
        readAck = 1'b1;
        @(posedge clk);
        #1;
        readAck = 1'b0;
      end
    join
    check("coinc_dout", DataOut, 8'h42);
    check("coinc_cr", charReceived, 1'b1);
    check("coinc_ov", overrun, 1'b0);
    do_ack();

    for (int i = 4; i < 7; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Randomized frames against the frame-level model
    m_dout = 8'h5A;
    m_cr = 1'b0;
    m_ov = 1'b0;
    for (int n = 0; n < 20; n++) begin
      logic [7:0] d;
      logic       stop;
      logic       ack;
      int         gap;
      d    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      ack  = 1'($urandom_range(0, 1));
      gap  = stop ? $urandom_range(0, 80) : $urandom_range(8, 80);
      fe0  = fe_cycles;
      send_frame(d, stop);
      idle(gap);
      if (stop) begin
        if (m_cr) m_ov = 1'b1;
        m_dout = d;
        m_cr = 1'b1;
      end
      check($sformatf("rnd%0d_dout", n), DataOut, m_dout);
      check($sformatf("rnd%0d_cr", n), charReceived, m_cr);
      check($sformatf("rnd%0d_ov", n), overrun, m_ov);
      check($sformatf("rnd%0d_fe", n), fe_cycles - fe0, stop ? 0 : 1);
      if (ack) begin
        do_ack();
        m_cr = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter CLKS_PER_TICK, default 326, number of CLOCK_50 cycles per 16x oversample tick (326 gives 9600 baud at 50 MHz); legal values are 2 or more.
REQ-002 Port CLOCK_50, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 Port DataIn, input, 1 bit: serial line, idle high, asynchronous to CLOCK_50.
REQ-005 Port readAck, input, 1 bit: consumer acknowledge; clears charReceived.
REQ-006 Port DataOut, output, 8 bits: last correctly framed character.
REQ-007 Port charReceived, output, 1 bit: character available, level held until acknowledged.
REQ-008 Port framingError, output, 1 bit: one-cycle pulse when the stop bit samples low.
REQ-009 Port overrun, output, 1 bit: sticky flag, set when a frame completes while charReceived=1.
REQ-010 Port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-011 Frame format: start bit 0, then 8 data bits MSB first (D7..D0), then stop bit 1; this matches the team transmitter's shift order.
REQ-012 DataIn passes through a 2-flop synchronizer before any use; this adds 2 cycles of input latency.
REQ-013 Tick generator: a free-running counter 0..CLKS_PER_TICK-1; tick is asserted for one cycle at the terminal count; the counter is held at 0 while in IDLE.
REQ-014 Every bit period is 16 ticks; the sample point is tick index 7 of the bit (mid-bit).
REQ-015 FSM states are IDLE, START, DATA, STOP.
REQ-016 IDLE -> START on a synchronized falling edge (previous sample 1, current sample 0); the tick counter and bit-tick counter clear on entry.
REQ-017 START: at tick index 7, if the line is 0 the FSM goes to DATA and the bit-tick counter restarts; if the line is 1 (glitch) the FSM returns to IDLE with no flags raised.
REQ-018 DATA: at each bit's tick 7, shift the sampled bit into the LSB of a shift register (left shift); after the 8th sample, go to STOP.
REQ-019 STOP: at tick 7, if the line is 1, load DataOut from the shift register and set charReceived the same cycle; if the line is 0, pulse framingError for one cycle and leave DataOut unchanged; both cases then go to IDLE.
REQ-020 Returning to IDLE at mid-stop-bit allows a back-to-back frame whose start edge arrives 8 ticks later.
REQ-021 charReceived clears on the cycle after readAck=1 is sampled; readAck while charReceived=0 has no effect.
REQ-022 If a valid stop bit and readAck coincide in the same cycle, charReceived stays 1 and DataOut takes the new character; overrun is not set.
REQ-023 If a valid stop bit arrives while charReceived=1 and readAck=0, DataOut is overwritten with the new character and overrun is set; overrun clears only on reset.
REQ-024 While in DATA, a line that is low at every sample yields data 0x00; the stop bit alone decides the frame's validity.
REQ-025 Latency: charReceived rises exactly 1 cycle after the stop-bit sample tick.

Reset
REQ-026 When reset=1 at a clock edge, the FSM goes to IDLE and all counters clear, mid-frame included; the partial frame is discarded.
REQ-027 Reset values: DataOut=0x00, charReceived=0, framingError=0, overrun=0, busy=0, both synchronizer flops=1.
REQ-028 With reset held high, DataIn activity has no effect on any output.

Verification (CLKS_PER_TICK=4, so 64 clocks per bit)
REQ-029 Frame 0xA5 sent MSB first (0,1,0,1,0,0,1,0,1,1) -> DataOut=0xA5, charReceived=1; pulse readAck -> charReceived=0 the next cycle.
REQ-030 Low pulse of 20 clocks on an idle line -> FSM returns to IDLE; charReceived, framingError and overrun all stay 0.
REQ-031 Frame 0x3C with stop bit forced to 0 -> framingError high for exactly 1 cycle; DataOut keeps its previous value; charReceived is unchanged.
REQ-032 Back-to-back frames 0x01 then 0xFE with no readAck -> DataOut=0xFE, overrun=1, charReceived=1.
REQ-033 Reset asserted for 1 cycle in the middle of D4 of a frame, then a clean frame 0x81 -> only 0x81 is reported; no framingError occurs.
REQ-034 Team transmitter connected directly to DataIn, sending 0x00, 0xFF and 0x5A at the same baud -> all three are received in order with readAck between each.
